alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Derived constant SHW = $clog2(WIDTH); shift amount = b[SHW-1:0].
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand / shift amount.
REQ-009 op  input  4  opcode (alu_pkg::alu_op_e).
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero, negative, carry, overflow  output  1 each  result flags.

Function
REQ-014 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SUBU, 0100 SRL, 1100 SRA, 0101 XOR, 0110 OR, 0111 AND, 1000 MUL (low WIDTH bits of a*b, unsigned), 1001 MULHU (high WIDTH bits of unsigned a*b); all others SHALL give result 0.
REQ-015 SRA SHALL be selected by opcode only; b[WIDTH-1] SHALL NOT affect shift type.
REQ-016 Handshake: transfer on in_valid && in_ready; result transfer on out_valid && out_ready.
REQ-017 FSM states IDLE, MUL_BUSY, HOLD; reset state IDLE.
REQ-018 in_ready SHALL be 1 in IDLE, or in HOLD when out_ready=1; 0 in MUL_BUSY.
REQ-019 Single-cycle op accepted in cycle N: result/flags registered, out_valid=1 from cycle N+1, state HOLD.
REQ-020 MUL/MULHU accepted in cycle N: state MUL_BUSY, shift-add one multiplier bit per cycle, out_valid=1 from cycle N+WIDTH, state HOLD.
REQ-021 In HOLD with out_ready=0: result, flags, out_valid SHALL stay stable.
REQ-022 In HOLD with out_ready=1 and no new transfer: next state IDLE, out_valid=0.
REQ-023 In HOLD with out_ready=1 and new transfer: back-to-back; new op processed per REQ-019/020 with no bubble for single-cycle ops.
REQ-024 Operands and op SHALL be captured at transfer; later input changes SHALL NOT affect an in-flight op.
REQ-025 zero = (result == 0); negative = result[WIDTH-1].
REQ-026 carry: ADD = carry-out of WIDTH-bit sum; SUB/SUBU = borrow (a < b unsigned); 0 for all other ops.
REQ-027 overflow: ADD/SUB = signed two's-complement overflow; 0 for all other ops (SUBU included).
REQ-028 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-029 rst SHALL force IDLE, out_valid=0, result=0, all flags 0, in_ready=0 during the reset cycle.
REQ-030 rst mid-MUL_BUSY or HOLD SHALL abort the operation; no result emitted after reset.
REQ-031 rst SHALL take priority over every handshake event in the same cycle.

Structure
REQ-032 Package alu_pkg SHALL hold alu_op_e opcode enum, alu_flags_t struct {zero, negative, carry, overflow}, and FSM state enum.
REQ-033 Iterative multiplier SHALL be sub-module alu_mul_iter (start, a, b -> done, 2*WIDTH product), parametrised by WIDTH.
REQ-034 Single-cycle datapath SHALL be combinational logic feeding one output register stage.

Verification
REQ-035 WIDTH=32, ADD a=0xFFFFFFFF b=1 -> result 0, zero=1, carry=1, overflow=0, out_valid 1 cycle after accept.
REQ-036 SUB a=0x80000000 b=1 -> result 0x7FFFFFFF, overflow=1, carry=0, negative=0.
REQ-037 SRA a=0x80000000 b=4 -> 0xF8000000; SRL same -> 0x08000000; SLL b=0x21 -> a<<1.
REQ-038 MUL a=0x00010000 b=0x00010000 -> result 0, zero=1, in_ready=0 for 32 cycles; MULHU same -> 1, out_valid at N+32.
REQ-039 out_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready=0; then out_ready=1 with new ADD -> back-to-back, no bubble.
REQ-040 rst asserted at cycle 10 of a MUL -> out_valid=0, IDLE next cycle, no stale result; repeat with WIDTH=8 and WIDTH=64.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, result flags, FSM states.
// Ports: none (package only).
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_SLL   = 4'b0010,
      OP_SUBU  = 4'b0011,
      OP_SRL   = 4'b0100,
      OP_XOR   = 4'b0101,
      OP_OR    = 4'b0110,
      OP_AND   = 4'b0111,
      OP_MUL   = 4'b1000,
      OP_MULHU = 4'b1001,
      OP_SRA   = 4'b1100
   } alu_op_e;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
   } alu_flags_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_BUSY = 2'd1,
      HOLD     = 2'd2
   } alu_state_e;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULHU);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports: clk, rst, start, a, b in; done, product (2*WIDTH) out.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;
   logic               busy;

   // Bit 0 is folded into the start cycle and the last bit is
   // presented combinationally, so the full product appears on
   // 'product' in the same cycle 'done' is high.
   always_comb begin
      acc_next = mplier[0] ? acc + mcand : acc;
   end

   assign done    = busy && (cnt == CW'(WIDTH - 1));
   assign product = acc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
         mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
         mplier <= {1'b0, b[WIDTH-1:1]};
         cnt    <= CW'(1);
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes and an iterative multiplier.
// Ports: clk, rst, in_valid/in_ready, a, b, op, out_valid/out_ready, result, flags.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   alu_state_e         state;
   alu_state_e         state_next;
   alu_op_e            op_e;
   alu_flags_t         flags;
   alu_flags_t         nxt_flags;

   logic               accept;
   logic               is_mul;
   logic               mul_start;
   logic               mul_done;
   logic               hi_sel;
   logic               load;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [WIDTH-1:0]   nxt_res;
   logic [WIDTH-1:0]   res;
   logic [SHW-1:0]     shamt;

   assign is_mul = is_mul_op(op);
   assign shamt  = b[SHW-1:0];

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (product)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) state_next = is_mul ? MUL_BUSY : HOLD;
         end
         MUL_BUSY: begin
            if (mul_done) state_next = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               if (accept) state_next = is_mul ? MUL_BUSY : HOLD;
               else        state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs; reset masks both sides in the reset cycle
   always_comb begin
      in_ready  = !rst && ((state == IDLE) ||
                           (state == HOLD && out_ready));
      out_valid = !rst && (state == HOLD);
      accept    = in_valid && in_ready;
      mul_start = accept && is_mul;
   end

   // Single-cycle datapath
   always_comb begin
      op_e    = alu_op_e'(op);
      sum     = {1'b0, a} + {1'b0, b};
      diff    = {1'b0, a} - {1'b0, b};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_e)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[MSB] == b[MSB]) &&
                      (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (a[MSB] != b[MSB]) &&
                      (diff[MSB] != a[MSB]);
         end
         OP_SUBU: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
         end
         OP_SLL: alu_res = a << shamt;
         OP_SRL: alu_res = a >> shamt;
         OP_SRA: alu_res = $unsigned($signed(a) >>> shamt);
         OP_XOR: alu_res = a ^ b;
         OP_OR:  alu_res = a | b;
         OP_AND: alu_res = a & b;
         default: alu_res = '0;
      endcase
   end

   // Select what the output register captures this cycle
   always_comb begin
      load    = 1'b0;
      nxt_res = alu_res;
      nxt_flags.carry    = alu_c;
      nxt_flags.overflow = alu_v;
      if (state == MUL_BUSY && mul_done) begin
         load    = 1'b1;
         nxt_res = hi_sel ? product[2*WIDTH-1:WIDTH]
                          : product[WIDTH-1:0];
         nxt_flags.carry    = 1'b0;
         nxt_flags.overflow = 1'b0;
      end else if (accept && !is_mul) begin
         load = 1'b1;
      end
      nxt_flags.zero     = (nxt_res == '0);
      nxt_flags.negative = nxt_res[MSB];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res    <= '0;
         flags  <= '0;
         hi_sel <= 1'b0;
      end else begin
         if (accept) hi_sel <= (op_e == OP_MULHU);
         if (load) begin
            res   <= nxt_res;
            flags <= nxt_flags;
         end
      end
   end

   assign result   = res;
   assign zero     = flags.zero;
   assign negative = flags.negative;
   assign carry    = flags.carry;
   assign overflow = flags.overflow;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH 8, 32 and 64.
// Ports: none (top-level bench).
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  iv;
   logic        out_ready;
   logic [3:0]  op;
   logic [63:0] a;
   logic [63:0] b;
   int          cur;
   int          total = 0;
   int          bad = 0;

   logic        ir8, ir32, ir64;
   logic        ov8, ov32, ov64;
   logic [7:0]  res8;
   logic [31:0] res32;
   logic [63:0] res64;
   logic [3:0]  fl8, fl32, fl64;
   logic        ov_m, ir_m;
   logic [67:0] rf_m;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir8),
      .a(a[7:0]), .b(b[7:0]), .op(op), .out_valid(ov8),
      .out_ready(out_ready), .result(res8), .zero(fl8[3]),
      .negative(fl8[2]), .carry(fl8[1]), .overflow(fl8[0])
   );

   alu_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir32),
      .a(a[31:0]), .b(b[31:0]), .op(op), .out_valid(ov32),
      .out_ready(out_ready), .result(res32), .zero(fl32[3]),
      .negative(fl32[2]), .carry(fl32[1]), .overflow(fl32[0])
   );

   alu_seq #(.WIDTH(64)) dut64 (
      .clk(clk), .rst(rst[2]), .in_valid(iv[2]), .in_ready(ir64),
      .a(a), .b(b), .op(op), .out_valid(ov64),
      .out_ready(out_ready), .result(res64), .zero(fl64[3]),
      .negative(fl64[2]), .carry(fl64[1]), .overflow(fl64[0])
   );

   always_comb begin
      ov_m = ov32;
      ir_m = ir32;
      rf_m = {32'b0, res32, fl32};
      case (cur)
         0: begin ov_m = ov8;  ir_m = ir8;  rf_m = {56'b0, res8, fl8}; end
         2: begin ov_m = ov64; ir_m = ir64; rf_m = {res64, fl64}; end
         default: ;
      endcase
   end

   typedef struct {
      int          d;
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] r;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   vec_t tv[28];

   task automatic chk(input string nm, input logic [67:0] act,
                      input logic [67:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_op(input int idx, input vec_t v);
      int lat;
      int busy_hi;
      @(negedge clk);
      cur = v.d; op = v.op; a = v.a; b = v.b;
      out_ready = 1'b1; iv[v.d] = 1'b1;
      #1 chk($sformatf("v%0d_ready", idx), 68'(ir_m), 68'(1));
      @(negedge clk);
      iv[v.d] = 1'b0;
      a = ~v.a; b = ~v.b; op = 4'hF;
      #1;
      lat = 1;
      busy_hi = 0;
      while (!ov_m && lat < 200) begin
         if (ir_m) busy_hi++;
         @(negedge clk);
         #1 lat++;
      end
      chk($sformatf("v%0d_lat", idx), 68'(lat), 68'(v.lat));
      if (v.lat > 1)
         chk($sformatf("v%0d_busy", idx), 68'(busy_hi), 68'(0));
      chk($sformatf("v%0d_res", idx), rf_m,
          {v.r, v.f});
   endtask

   task automatic reset_mul(input int d, input int w);
      bit seen;
      int at;
      at = (w > 12) ? 10 : 4;
      @(negedge clk);
      cur = d; op = OP_MUL; a = 64'h5; b = 64'h7;
      out_ready = 1'b1; iv[d] = 1'b1;
      @(negedge clk);
      iv[d] = 1'b0;
      repeat (at - 1) @(negedge clk);
      rst[d] = 1'b1;
      iv[d] = 1'b1; op = OP_ADD; a = 64'h1; b = 64'h1;
      #1;
      chk($sformatf("w%0d_rst_ready", w), 68'(ir_m), 68'(0));
      chk($sformatf("w%0d_rst_valid", w), 68'(ov_m), 68'(0));
      @(negedge clk);
      rst[d] = 1'b0;
      iv[d] = 1'b0;
      #1;
      chk($sformatf("w%0d_post_valid", w), 68'(ov_m), 68'(0));
      chk($sformatf("w%0d_post_res", w), rf_m, 68'(0));
      chk($sformatf("w%0d_post_idle", w), 68'(ir_m), 68'(1));
      seen = 1'b0;
      repeat (2 * w + 4) begin
         @(negedge clk);
         #1 if (ov_m) seen = 1'b1;
      end
      chk($sformatf("w%0d_no_stale", w), 68'(seen), 68'(0));
   endtask

   initial begin
      tv[0]  = '{1, OP_ADD,   64'hFFFFFFFF, 64'h1, 64'h0, 4'b1010, 1};
      tv[1]  = '{1, OP_SUB,   64'h80000000, 64'h1, 64'h7FFFFFFF, 4'b0001, 1};
      tv[2]  = '{1, OP_SRA,   64'h80000000, 64'h4, 64'hF8000000, 4'b0100, 1};
      tv[3]  = '{1, OP_SRL,   64'h80000000, 64'h4, 64'h08000000, 4'b0000, 1};
      tv[4]  = '{1, OP_SLL,   64'h40000001, 64'h21, 64'h80000002, 4'b0100, 1};
      tv[5]  = '{1, OP_SRL,   64'h80000000, 64'h80000004, 64'h08000000, 4'b0000, 1};
      tv[6]  = '{1, OP_ADD,   64'h7FFFFFFF, 64'h1, 64'h80000000, 4'b0101, 1};
      tv[7]  = '{1, OP_SUBU,  64'h80000000, 64'h1, 64'h7FFFFFFF, 4'b0000, 1};
      tv[8]  = '{1, OP_SUB,   64'h1, 64'h2, 64'hFFFFFFFF, 4'b0110, 1};
      tv[9]  = '{1, OP_SUBU,  64'h1, 64'h2, 64'hFFFFFFFF, 4'b0110, 1};
      tv[10] = '{1, OP_SUB,   64'h3, 64'h3, 64'h0, 4'b1000, 1};
      tv[11] = '{1, OP_XOR,   64'hF0F0F0F0, 64'hFF00FF00, 64'h0FF00FF0, 4'b0000, 1};
      tv[12] = '{1, OP_OR,    64'h12340000, 64'h5678, 64'h12345678, 4'b0000, 1};
      tv[13] = '{1, OP_AND,   64'hF0F0F0F0, 64'h0FF00FF0, 64'h00F000F0, 4'b0000, 1};
      tv[14] = '{1, 4'hA,     64'h5, 64'h3, 64'h0, 4'b1000, 1};
      tv[15] = '{1, OP_SRA,   64'h80000000, 64'h1F, 64'hFFFFFFFF, 4'b0100, 1};
      tv[16] = '{1, OP_MUL,   64'h00010000, 64'h00010000, 64'h0, 4'b1000, 32};
      tv[17] = '{1, OP_MULHU, 64'h00010000, 64'h00010000, 64'h1, 4'b0000, 32};
      tv[18] = '{1, OP_MUL,   64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1, 4'b0000, 32};
      tv[19] = '{1, OP_MULHU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 4'b0100, 32};
      tv[20] = '{1, OP_SUB,   64'h7FFFFFFF, 64'hFFFFFFFF, 64'h80000000, 4'b0111, 1};
      tv[21] = '{1, OP_ADD,   64'h80000000, 64'h80000000, 64'h0, 4'b1011, 1};
      tv[22] = '{0, OP_ADD,   64'hFF, 64'h01, 64'h00, 4'b1010, 1};
      tv[23] = '{0, OP_MULHU, 64'hFF, 64'hFF, 64'hFE, 4'b0100, 8};
      tv[24] = '{0, OP_SRA,   64'h80, 64'h0B, 64'hF0, 4'b0100, 1};
      tv[25] = '{2, OP_MUL,   64'hFFFFFFFFFFFFFFFF, 64'h2,
                 64'hFFFFFFFFFFFFFFFE, 4'b0100, 64};
      tv[26] = '{2, OP_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h1, 4'b0000, 64};
      tv[27] = '{2, OP_ADD,   64'h7FFFFFFFFFFFFFFF, 64'h1,
                 64'h8000000000000000, 4'b0101, 1};

      rst = 3'b111; iv = 3'b000; out_ready = 1'b1;
      op = OP_ADD; a = '0; b = '0; cur = 1;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", 68'(ir_m), 68'(0));
      chk("rst_valid", 68'(ov_m), 68'(0));
      @(negedge clk);
      rst = 3'b000;
      #1;
      chk("idle_ready", 68'(ir_m), 68'(1));
      chk("idle_valid", 68'(ov_m), 68'(0));
      chk("idle_res", rf_m, 68'(0));

      for (int i = 0; i < 28; i++) run_op(i, tv[i]);

      // Output stall in HOLD, then back-to-back ADD
      @(negedge clk);
      cur = 1; op = OP_ADD; a = 64'd1; b = 64'd2;
      out_ready = 1'b0; iv[1] = 1'b1;
      #1 chk("stall_accept", 68'(ir_m), 68'(1));
      @(negedge clk);
      a = 64'd10; b = 64'd20;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("stall%0d_valid", k), 68'(ov_m), 68'(1));
         chk($sformatf("stall%0d_res", k), rf_m, {64'd3, 4'b0000});
         chk($sformatf("stall%0d_ready", k), 68'(ir_m), 68'(0));
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("b2b_ready", 68'(ir_m), 68'(1));
      @(negedge clk);
      iv[1] = 1'b0;
      #1;
      chk("b2b_valid", 68'(ov_m), 68'(1));
      chk("b2b_res", rf_m, {64'd30, 4'b0000});
      @(negedge clk);
      #1 chk("b2b_drain", 68'(ov_m), 68'(0));

      reset_mul(1, 32);
      reset_mul(0, 8);
      reset_mul(2, 64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
